// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared definitions for the virtual-channel FIFO drain arbiter: FSM encoding,
// default geometry and the round-robin rotate-and-find-first search.
package fifo_drain_arbiter_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int NUM_CH_DEF = 4;
  localparam int CH_W_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // First set bit of req[n-1:0] searching ptr, ptr+1, ... modulo n (n a power
  // of two, at most 32); -1 when nothing is requested.
  function automatic int rr_find_first(input logic [31:0] req, input int ptr, input int n);
    int hit;
    int idx;
    hit = -1;
    for (int k = 31; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) & (n - 1);
        if (req[idx[4:0]]) hit = idx;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// Bundle between the drain arbiter, the FIFO bank read side and the
// downstream consumer. The arbiter uses the master view.
interface fifo_drain_arbiter_if
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = CH_W_DEF
);
  logic                     enable;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH-1:0]        fifo_almost_empty;
  logic [NUM_CH*DATA_W-1:0] fifo_data;
  logic [NUM_CH-1:0]        dest_almost_full;
  logic [NUM_CH-1:0]        pop;
  logic [DATA_W-1:0]        data_out;
  logic                     valid_out;
  logic [CH_W-1:0]          ch_out;
  logic                     idle_out;

  modport master (
    input  enable, fifo_empty, fifo_almost_empty, fifo_data, dest_almost_full,
    output pop, data_out, valid_out, ch_out, idle_out
  );

  modport slave (
    output enable, fifo_empty, fifo_almost_empty, fifo_data, dest_almost_full,
    input  pop, data_out, valid_out, ch_out, idle_out
  );
endinterface

// File: rtl/fifo_drain_arbiter_rr_grant.sv
// Combinational round-robin grant: first eligible channel at or after rr_ptr,
// returned both one-hot and as an index.
module rr_grant
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic [NUM_CH-1:0] elig_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   gnt_idx_o,
  output logic              any_o
);
  logic [31:0] req_ext;
  int          first;

  always_comb begin
    req_ext               = '0;
    req_ext[NUM_CH-1:0]   = elig_i;
    first                 = rr_find_first(req_ext, int'(rr_ptr_i), NUM_CH);
    any_o                 = (first >= 0);
    gnt_o                 = '0;
    gnt_idx_o             = '0;
    if (any_o) begin
      gnt_idx_o        = first[CH_W-1:0];
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end
endmodule

// File: rtl/fifo_drain_arbiter.sv
// Read-side controller for the virtual-channel FIFO bank: picks one FIFO per
// cycle round-robin, and returns the popped word two cycles later with its channel.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = CH_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_drain_arbiter_if.master bus
);
  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0] last_pop_q;
  logic [NUM_CH-1:0] cand, elig, gnt, pop_sel;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              pend_vld_p1_q;
  logic [CH_W-1:0]   pend_ch_p1_q;
  logic              vld_p2_q;
  logic [CH_W-1:0]   ch_p2_q;
  logic [DATA_W-1:0] data_p2_q;
  logic [DATA_W-1:0] rd_word;

  // The FIFO flags lag a pop by one cycle, so a channel popped last cycle that
  // now reads almost-empty may hold nothing more: hold it off for a cycle.
  assign cand = ~bus.fifo_empty & ~bus.dest_almost_full;
  assign elig = cand & ~(last_pop_q & bus.fifo_almost_empty);

  rr_grant #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr_grant (
    .elig_i    (elig),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_comb begin
    state_d = state_q;
    pop_sel = '0;
    case (state_q)
      IDLE: begin
        if (bus.enable && gnt_any) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!bus.enable) begin
          state_d = pend_vld_p1_q ? DRAIN : IDLE;
        end else begin
          pop_sel = gnt;
          // A one-cycle hold-off is not a reason to give up the ACTIVE state.
          if (!(|cand)) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (!pend_vld_p1_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) pop_sel = '0;
  end

  assign rr_ptr_d = (|pop_sel) ? gnt_idx + CH_W'(1) : rr_ptr_q;
  assign rd_word  = bus.fifo_data[pend_ch_p1_q*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      last_pop_q    <= '0;
      pend_vld_p1_q <= 1'b0;
      pend_ch_p1_q  <= '0;
      vld_p2_q      <= 1'b0;
      ch_p2_q       <= '0;
      data_p2_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      last_pop_q <= pop_sel;
      // Stage 1: pop issued, FIFO RAM read in flight
      pend_vld_p1_q <= |pop_sel;
      if (|pop_sel) pend_ch_p1_q <= gnt_idx;
      // Stage 2: capture the returned word
      vld_p2_q <= pend_vld_p1_q;
      if (pend_vld_p1_q) begin
        ch_p2_q   <= pend_ch_p1_q;
        data_p2_q <= rd_word;
      end
    end
  end

  assign bus.pop       = pop_sel;
  assign bus.data_out  = data_p2_q;
  assign bus.valid_out = vld_p2_q;
  assign bus.ch_out    = ch_p2_q;
  assign bus.idle_out  = !pend_vld_p1_q && (pop_sel == '0);
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: a queue-based FIFO bank model feeds the DUT and
// directed plus randomized scenarios are checked against spec-level expectations.
module tb_fifo_drain_arbiter;
  import fifo_drain_arbiter_pkg::*;

  localparam int DATA_W = 6;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef struct {
    int              cyc;
    logic [CH_W-1:0] ch;
    word_t           d;
  } infl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_drain_arbiter_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  fifo_drain_arbiter #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // FIFO bank model and expected per-channel output order
  word_t             fq [NUM_CH][$];
  word_t             sb [NUM_CH][$];
  word_t             rd [NUM_CH];
  logic [NUM_CH-1:0] emp, ae, af;
  logic              en;

  // Per-cycle samples taken mid-cycle
  logic [NUM_CH-1:0] pop_s, prev_pop_s, emp_s, ae_s, af_s;
  logic              en_s, vo_s, idle_s;
  word_t             do_s, pw_s;
  logic [CH_W-1:0]   ch_s;

  task automatic push(input int c, input word_t v);
    fq[c].push_back(v);
    sb[c].push_back(v);
  endtask

  task automatic update_flags();
    for (int c = 0; c < NUM_CH; c++) begin
      emp[c] = (fq[c].size() == 0);
      ae[c]  = (fq[c].size() <= 1);
    end
  endtask

  task automatic drive_inputs();
    bus.enable            = en;
    bus.fifo_empty        = emp;
    bus.fifo_almost_empty = ae;
    bus.dest_almost_full  = af;
    for (int c = 0; c < NUM_CH; c++) bus.fifo_data[c*DATA_W +: DATA_W] = rd[c];
  endtask

  task automatic preload(input int depth);
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < depth; j++) push(c, word_t'($urandom_range(0, 63)));
    update_flags();
  endtask

  // Sample at the falling edge, then apply the FIFO reaction to the rising edge.
  task automatic step();
    @(negedge clk);
    prev_pop_s = pop_s;
    pop_s  = bus.pop;
    vo_s   = bus.valid_out;
    do_s   = bus.data_out;
    ch_s   = bus.ch_out;
    idle_s = bus.idle_out;
    emp_s  = emp;
    ae_s   = ae;
    af_s   = af;
    en_s   = en;
    pw_s   = '0;
    for (int c = 0; c < NUM_CH; c++) if (pop_s[c] && fq[c].size() > 0) pw_s = fq[c][0];
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) if (pop_s[c] && fq[c].size() > 0) rd[c] = fq[c].pop_front();
    update_flags();
    drive_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    af    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fq[c].delete();
      sb[c].delete();
      rd[c] = '0;
    end
    update_flags();
    drive_inputs();
    pop_s = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    preload(3);
    en = 1'b1;
    af = '0;
    drive_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.pop !== '0) begin n_mis++; $display("FAIL reset_pop: got %b want 0000", bus.pop); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.idle_out !== 1'b1) begin n_mis++; $display("FAIL reset_idle: got %b want 1", bus.idle_out); end
    n_cmp++; if (bus.data_out !== '0) begin n_mis++; $display("FAIL reset_data: got %0d want 0", bus.data_out); end
    n_cmp++; if (bus.ch_out !== '0) begin n_mis++; $display("FAIL reset_ch: got %0d want 0", bus.ch_out); end
  endtask

  task automatic test_reset_midstream();
    int  npop;
    bit  found;
    do_reset();
    preload(10);
    en = 1'b1;
    drive_inputs();
    npop = 0;
    for (int i = 0; i < 8 && npop < 2; i++) begin
      step();
      if (pop_s != '0) npop++;
    end
    n_cmp++; if (npop != 2) begin n_mis++; $display("FAIL midrst_pops: got %0d pops want 2", npop); end
    n_cmp++; if (bus.idle_out !== 1'b0) begin n_mis++; $display("FAIL midrst_busy: idle_out got %b want 0", bus.idle_out); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.pop !== '0) begin n_mis++; $display("FAIL midrst_pop: got %b want 0000", bus.pop); end
    n_cmp++; if (bus.valid_out !== 1'b0) begin n_mis++; $display("FAIL midrst_valid: got %b want 0", bus.valid_out); end
    n_cmp++; if (bus.idle_out !== 1'b1) begin n_mis++; $display("FAIL midrst_idle: got %b want 1", bus.idle_out); end
    step();
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      if (pop_s != '0) begin
        found = 1'b1;
        n_cmp++; if (pop_s !== 4'b0001) begin n_mis++; $display("FAIL midrst_first_grant: got %b want 0001", pop_s); end
      end
    end
    n_cmp++; if (!found) begin n_mis++; $display("FAIL midrst_no_grant: got none want pop within 6 cycles"); end
  endtask

  task automatic test_round_robin();
    logic [NUM_CH-1:0] pops [12];
    logic              vos  [12];
    logic [CH_W-1:0]   chs  [12];
    word_t             dos  [12];
    logic [NUM_CH-1:0] exp_pop;
    word_t             exp_d;
    int                f;
    do_reset();
    preload(10);
    en = 1'b1;
    drive_inputs();
    for (int i = 0; i < 12; i++) begin
      step();
      pops[i] = pop_s; vos[i] = vo_s; chs[i] = ch_s; dos[i] = do_s;
    end
    f = -1;
    for (int i = 0; i < 4; i++) if (f < 0 && pops[i] != '0) f = i;
    n_cmp++;
    if (f < 0) begin
      n_mis++; $display("FAIL rr_start: got no pop want pop within 4 cycles");
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_pop = NUM_CH'(1) << (i % NUM_CH);
        exp_d   = sb[i % NUM_CH].pop_front();
        n_cmp++; if (pops[f+i] !== exp_pop) begin n_mis++; $display("FAIL rr_pop[%0d]: got %b want %b", i, pops[f+i], exp_pop); end
        n_cmp++; if (vos[f+2+i] !== 1'b1 || chs[f+2+i] !== CH_W'(i % NUM_CH)) begin
          n_mis++; $display("FAIL rr_out[%0d]: got v=%b ch=%0d want v=1 ch=%0d", i, vos[f+2+i], chs[f+2+i], i % NUM_CH);
        end
        n_cmp++; if (dos[f+2+i] !== exp_d) begin n_mis++; $display("FAIL rr_data[%0d]: got %0d want %0d", i, dos[f+2+i], exp_d); end
      end
    end
  endtask

  task automatic test_single_near_empty();
    logic [NUM_CH-1:0] pops [10];
    logic              vos  [10];
    word_t             dos  [10];
    word_t             w0, w1;
    int                k, nvalid;
    bit                extra;
    do_reset();
    push(2, word_t'($urandom_range(0, 63)));
    push(2, word_t'($urandom_range(0, 63)));
    w0 = sb[2][0];
    w1 = sb[2][1];
    update_flags();
    en = 1'b1;
    drive_inputs();
    for (int i = 0; i < 10; i++) begin
      step();
      pops[i] = pop_s; vos[i] = vo_s; dos[i] = do_s;
    end
    k = -1;
    for (int i = 0; i < 4; i++) if (k < 0 && pops[i] != '0) k = i;
    n_cmp++;
    if (k < 0) begin
      n_mis++; $display("FAIL single_start: got no pop want pop within 4 cycles");
    end else begin
      n_cmp++; if (pops[k] !== 4'b0100) begin n_mis++; $display("FAIL single_pop_k: got %b want 0100", pops[k]); end
      n_cmp++; if (pops[k+1] !== 4'b0000) begin n_mis++; $display("FAIL single_pop_k1: got %b want 0000", pops[k+1]); end
      n_cmp++; if (pops[k+2] !== 4'b0100) begin n_mis++; $display("FAIL single_pop_k2: got %b want 0100", pops[k+2]); end
      extra = 1'b0;
      for (int i = k + 3; i < 10; i++) if (pops[i] != '0) extra = 1'b1;
      n_cmp++; if (extra) begin n_mis++; $display("FAIL single_pop_empty: got pop after empty want none"); end
      n_cmp++; if (vos[k+2] !== 1'b1 || dos[k+2] !== w0) begin n_mis++; $display("FAIL single_word0: got v=%b d=%0d want v=1 d=%0d", vos[k+2], dos[k+2], w0); end
      n_cmp++; if (vos[k+4] !== 1'b1 || dos[k+4] !== w1) begin n_mis++; $display("FAIL single_word1: got v=%b d=%0d want v=1 d=%0d", vos[k+4], dos[k+4], w1); end
    end
    nvalid = 0;
    for (int i = 0; i < 10; i++) if (vos[i]) nvalid++;
    n_cmp++; if (nvalid != 2) begin n_mis++; $display("FAIL single_count: got %0d words want 2", nvalid); end
  endtask

  task automatic test_backpressure();
    int exp_g [6] = '{0, 2, 3, 0, 2, 3};
    int grants [$];
    int g;
    bit saw1, found;
    do_reset();
    preload(12);
    af = 4'b0010;
    en = 1'b1;
    drive_inputs();
    saw1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pop_s[1]) saw1 = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (pop_s[c]) grants.push_back(c);
    end
    n_cmp++; if (saw1) begin n_mis++; $display("FAIL bp_masked: got pop on ch1 want none"); end
    for (int j = 0; j < 6; j++) begin
      g = (j < grants.size()) ? grants[j] : -1;
      n_cmp++; if (g != exp_g[j]) begin n_mis++; $display("FAIL bp_order[%0d]: got %0d want %0d", j, g, exp_g[j]); end
    end
    af = '0;
    drive_inputs();
    found = 1'b0;
    for (int i = 0; i < NUM_CH && !found; i++) begin
      step();
      if (pop_s[1]) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_mis++; $display("FAIL bp_release: got no ch1 grant want one within %0d cycles", NUM_CH); end
  endtask

  task automatic test_enable_drop();
    bit found;
    do_reset();
    preload(10);
    en = 1'b1;
    drive_inputs();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (pop_s[3]) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_mis++; $display("FAIL drop_setup: got no ch3 pop want one within 10 cycles"); end
    en = 1'b0;
    drive_inputs();
    step();
    n_cmp++; if (pop_s !== '0) begin n_mis++; $display("FAIL drop_pop: got %b want 0000", pop_s); end
    n_cmp++; if (vo_s !== 1'b1 || ch_s !== 2'd2) begin n_mis++; $display("FAIL drop_out1: got v=%b ch=%0d want v=1 ch=2", vo_s, ch_s); end
    step();
    n_cmp++; if (vo_s !== 1'b1 || ch_s !== 2'd3) begin n_mis++; $display("FAIL drop_out2: got v=%b ch=%0d want v=1 ch=3", vo_s, ch_s); end
    step();
    n_cmp++; if (vo_s !== 1'b0) begin n_mis++; $display("FAIL drop_out3: got v=%b want 0", vo_s); end
    n_cmp++; if (idle_s !== 1'b1) begin n_mis++; $display("FAIL drop_idle: got %b want 1", idle_s); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL drop_state: got %0d want %0d", dut.state_q, IDLE); end
  endtask

  task automatic test_data_integrity();
    infl_t           infl [$];
    infl_t           e;
    logic [CH_W-1:0] c_idx;
    bit              exp_v, legal, exp_idle;
    word_t           exp_d;
    do_reset();
    en = 1'b1;
    drive_inputs();
    for (int n = 0; n < 1200; n++) begin
      if (n < 1000) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (fq[c].size() < 6 && $urandom_range(0, 99) < 45) push(c, word_t'($urandom_range(0, 63)));
          af[c] = ($urandom_range(0, 99) < 20);
        end
        en = ($urandom_range(0, 99) < 92);
      end else begin
        af = '0;
        en = 1'b1;
      end
      drive_inputs();
      step();
      n_cmp++; if (!$onehot0(pop_s)) begin n_mis++; $display("FAIL di_onehot@%0d: got %b want at most one bit", n, pop_s); end
      if (!en_s) begin
        n_cmp++; if (pop_s !== '0) begin n_mis++; $display("FAIL di_disabled@%0d: got %b want 0000", n, pop_s); end
      end
      exp_idle = (prev_pop_s == '0) && (pop_s == '0);
      n_cmp++; if (idle_s !== exp_idle) begin n_mis++; $display("FAIL di_idle@%0d: got %b want %b", n, idle_s, exp_idle); end
      exp_v = (infl.size() > 0) && (infl[0].cyc == n - 2);
      n_cmp++; if (vo_s !== exp_v) begin n_mis++; $display("FAIL di_valid@%0d: got %b want %b", n, vo_s, exp_v); end
      if (exp_v) begin
        e = infl.pop_front();
        n_cmp++; if (ch_s !== e.ch || do_s !== e.d) begin
          n_mis++; $display("FAIL di_latency@%0d: got ch=%0d d=%0d want ch=%0d d=%0d", n, ch_s, do_s, e.ch, e.d);
        end
      end
      if (vo_s) begin
        exp_d = (sb[ch_s].size() > 0) ? sb[ch_s].pop_front() : 'x;
        n_cmp++; if (do_s !== exp_d) begin n_mis++; $display("FAIL di_order@%0d ch%0d: got %0d want %0d", n, ch_s, do_s, exp_d); end
      end
      if (pop_s != '0) begin
        c_idx = '0;
        for (int c = 0; c < NUM_CH; c++) if (pop_s[c]) c_idx = CH_W'(c);
        legal = !emp_s[c_idx] && !af_s[c_idx] && !(prev_pop_s[c_idx] && ae_s[c_idx]);
        n_cmp++; if (!legal) begin
          n_mis++; $display("FAIL di_elig@%0d: got pop ch%0d e=%b ae=%b af=%b prev=%b want eligible channel", n, c_idx, emp_s, ae_s, af_s, prev_pop_s);
        end
        infl.push_back('{cyc: n, ch: c_idx, d: pw_s});
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      n_cmp++; if (sb[c].size() != 0) begin n_mis++; $display("FAIL di_drain ch%0d: got %0d words undelivered want 0", c, sb[c].size()); end
    end
    n_cmp++; if (infl.size() != 0) begin n_mis++; $display("FAIL di_inflight: got %0d pops unanswered want 0", infl.size()); end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    af    = '0;
    pop_s = '0;
    for (int c = 0; c < NUM_CH; c++) rd[c] = '0;
    update_flags();
    drive_inputs();
    test_reset();
    test_reset_midstream();
    test_round_robin();
    test_single_near_empty();
    test_backpressure();
    test_enable_drop();
    test_data_integrity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
